// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional encoder frame sequencer.
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      DATA  = 3'd2,
      TAIL  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   // Encoder memory length; this many zeros flush the encoder back to all-zero.
   localparam int CONV_TAIL_LEN = 3;

endpackage

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder, r3 newest; out[1]=r3^r1^r0, out[0]=r3^r2^r1^r0.
module conv_encoder (
   input  logic       clk_sig,
   input  logic       rst_sig,
   input  logic       clr_sig,
   input  logic       en_sig,
   input  logic       q_sig,
   output logic [1:0] encode_sig
);

   logic [3:0] r;

   // A shift wins over a clear so the first payload bit is never lost.
   always_ff @(posedge clk_sig or posedge rst_sig) begin
      if (rst_sig)      r <= '0;
      else if (!en_sig) r <= {q_sig, r[3:1]};
      else if (clr_sig) r <= '0;
   end

   assign encode_sig = {r[3] ^ r[1] ^ r[0], r[3] ^ r[2] ^ r[1] ^ r[0]};

endmodule

// File: rtl/conv_encode_ctrl.sv
// Frame sequencer: clears the encoder, shifts payload then zero tail bits, streams symbols.
module conv_encode_ctrl
   import conv_pkg::*;
#(
   parameter int FRAME_LEN = 64,
   parameter int TAIL_LEN  = CONV_TAIL_LEN
) (
   input  logic       clk_sig,
   input  logic       rst_sig,
   input  logic       start_sig,
   input  logic       abort_sig,
   input  logic       bit_sig,
   input  logic       bit_valid_sig,
   output logic       bit_ready_sig,
   output logic       enc_q_sig,
   output logic       enc_en_sig,
   output logic       enc_rst_sig,
   input  logic [1:0] encode_sig,
   output logic [1:0] sym_sig,
   output logic       sym_valid_sig,
   input  logic       sym_ready_sig,
   output logic       sym_last_sig,
   output logic       busy_sig,
   output logic       done_sig
);

   localparam int BW = $clog2(FRAME_LEN + 1);
   localparam int TW = $clog2(TAIL_LEN + 1);

   state_t        state;
   logic [BW-1:0] bit_cnt;
   logic [TW-1:0] tail_cnt;
   logic          can_issue;
   logic          shift;

   assign can_issue     = !sym_valid_sig | sym_ready_sig;
   assign shift         = ((state == DATA) & bit_valid_sig & can_issue) | ((state == TAIL) & can_issue);
   assign bit_ready_sig = (state == DATA) & can_issue;
   assign enc_en_sig    = ~shift;
   assign enc_q_sig     = (state == DATA) ? bit_sig : 1'b0;
   // Encoder holds while a symbol is pending, so its output is the pending symbol.
   assign sym_sig       = sym_valid_sig ? encode_sig : 2'b00;

   always_ff @(posedge clk_sig or posedge rst_sig) begin
      if (rst_sig) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         tail_cnt      <= '0;
         sym_valid_sig <= 1'b0;
         sym_last_sig  <= 1'b0;
         enc_rst_sig   <= 1'b0;
         busy_sig      <= 1'b0;
         done_sig      <= 1'b0;
      end else begin
         done_sig    <= 1'b0;
         enc_rst_sig <= 1'b0;
         if (abort_sig) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            tail_cnt      <= '0;
            sym_valid_sig <= 1'b0;
            sym_last_sig  <= 1'b0;
            busy_sig      <= 1'b0;
         end else begin
            if (shift)              sym_valid_sig <= 1'b1;
            else if (sym_ready_sig) sym_valid_sig <= 1'b0;
            case (state)
               IDLE: if (start_sig) begin
                  state       <= CLEAR;
                  enc_rst_sig <= 1'b1;
                  busy_sig    <= 1'b1;
                  bit_cnt     <= '0;
                  tail_cnt    <= '0;
               end
               CLEAR: state <= DATA;
               DATA: if (shift) begin
                  if (bit_cnt == BW'(FRAME_LEN - 1)) state <= TAIL;
                  else bit_cnt <= bit_cnt + BW'(1);
               end
               TAIL: if (shift) begin
                  if (tail_cnt == TW'(TAIL_LEN - 1)) begin
                     state        <= DRAIN;
                     sym_last_sig <= 1'b1;
                  end else begin
                     tail_cnt <= tail_cnt + TW'(1);
                  end
               end
               DRAIN: if (sym_valid_sig & sym_ready_sig & sym_last_sig) begin
                  state        <= IDLE;
                  sym_last_sig <= 1'b0;
                  busy_sig     <= 1'b0;
                  done_sig     <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conv_encode_ctrl.sv
// Bench for conv_encode_ctrl driving a real conv_encoder, checked against a symbol-list model.
module tb_conv_encode_ctrl;

   localparam int N = 4;
   localparam int T = 3;

   logic       clk_sig = 1'b0;
   bit         clk_run = 1'b1;
   logic       rst_sig, start_sig, abort_sig, bit_sig, bit_valid_sig, sym_ready_sig;
   logic       bit_ready_sig, enc_q_sig, enc_en_sig, enc_rst_sig;
   logic [1:0] encode_sig, sym_sig;
   logic       sym_valid_sig, sym_last_sig, busy_sig, done_sig;

   int passed = 0;
   int total  = 0;

   always begin
      #5;
      if (clk_run) clk_sig = ~clk_sig;
   end

   conv_encode_ctrl #(.FRAME_LEN(N), .TAIL_LEN(T)) dut (
      .clk_sig(clk_sig), .rst_sig(rst_sig), .start_sig(start_sig), .abort_sig(abort_sig),
      .bit_sig(bit_sig), .bit_valid_sig(bit_valid_sig), .bit_ready_sig(bit_ready_sig),
      .enc_q_sig(enc_q_sig), .enc_en_sig(enc_en_sig), .enc_rst_sig(enc_rst_sig),
      .encode_sig(encode_sig), .sym_sig(sym_sig), .sym_valid_sig(sym_valid_sig),
      .sym_ready_sig(sym_ready_sig), .sym_last_sig(sym_last_sig),
      .busy_sig(busy_sig), .done_sig(done_sig)
   );

   conv_encoder enc (
      .clk_sig(clk_sig), .rst_sig(rst_sig), .clr_sig(enc_rst_sig),
      .en_sig(enc_en_sig), .q_sig(enc_q_sig), .encode_sig(encode_sig)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Symbol k comes from the k-th bit of payload followed by T zeros and the three before it.
   function automatic logic [1:0] exp_sym(input logic [N-1:0] bits, input int k);
      int s [4];
      for (int j = 0; j < 4; j++) begin
         int idx = k - j;
         s[j] = (idx >= 0 && idx < N) ? int'(bits[idx]) : 0;
      end
      return {1'(s[0] ^ s[2] ^ s[3]), 1'(s[0] ^ s[1] ^ s[2] ^ s[3])};
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_bit_ready"}, 32'(bit_ready_sig), 0);
      chk({tag, "_enc_en"},    32'(enc_en_sig), 1);
      chk({tag, "_enc_q"},     32'(enc_q_sig), 0);
      chk({tag, "_enc_rst"},   32'(enc_rst_sig), 0);
      chk({tag, "_sym_valid"}, 32'(sym_valid_sig), 0);
      chk({tag, "_sym_last"},  32'(sym_last_sig), 0);
      chk({tag, "_sym"},       32'(sym_sig), 0);
      chk({tag, "_busy"},      32'(busy_sig), 0);
      chk({tag, "_done"},      32'(done_sig), 0);
   endtask

   // rmode: 0 ready high, 1 ready low in cycles 4..6, 2 random.
   // vmode: 0 valid high, 1 valid low on odd cycles, 2 random.
   task automatic run_frame(input string tag, input logic [N-1:0] bits, input int rmode,
                            input int vmode, input int abort_at, input int stop_at,
                            input int exp_done_cyc);
      int  acc = 0, tails = 0, issued = 0, sidx = 0;
      bit  done_due = 0, fin = 0;
      bit  exp_valid, can_issue, exp_shift;
      int  cyc = 0;
      while (!fin && cyc < 300) begin
         @(posedge clk_sig); #1;
         start_sig = (cyc == 0);
         abort_sig = (cyc == abort_at);
         case (rmode)
            0:       sym_ready_sig = 1'b1;
            1:       sym_ready_sig = !(cyc >= 4 && cyc <= 6);
            default: sym_ready_sig = ($urandom % 4) != 0;
         endcase
         case (vmode)
            0:       bit_valid_sig = 1'b1;
            1:       bit_valid_sig = (cyc % 2) == 0;
            default: bit_valid_sig = 1'($urandom % 2);
         endcase
         bit_sig = (bit_valid_sig && acc < N) ? bits[acc] : 1'($urandom % 2);
         #1;
         if (abort_at >= 0 && cyc == abort_at + 1) begin
            chk({tag, "_abort_valid"}, 32'(sym_valid_sig), 0);
            chk({tag, "_abort_busy"},  32'(busy_sig), 0);
            chk({tag, "_abort_done"},  32'(done_sig), 0);
            chk({tag, "_abort_bready"}, 32'(bit_ready_sig), 0);
            return;
         end
         exp_valid = issued > sidx;
         can_issue = !exp_valid || sym_ready_sig;
         exp_shift = (cyc >= 2) && can_issue && ((acc < N) ? bit_valid_sig : (tails < T));
         chk({tag, "_enc_en"},    32'(enc_en_sig), 32'(!exp_shift));
         chk({tag, "_bit_ready"}, 32'(bit_ready_sig), 32'((cyc >= 2) && acc < N && can_issue));
         chk({tag, "_enc_rst"},   32'(enc_rst_sig), 32'(cyc == 1));
         chk({tag, "_sym_valid"}, 32'(sym_valid_sig), 32'(exp_valid));
         chk({tag, "_sym_last"},  32'(sym_last_sig), 32'(exp_valid && sidx == N + T - 1));
         chk({tag, "_done"},      32'(done_sig), 32'(done_due));
         chk({tag, "_busy"},      32'(busy_sig), 32'(cyc >= 1 && !done_due));
         if (exp_valid) chk({tag, "_sym"}, 32'(sym_sig), 32'(exp_sym(bits, sidx)));
         if (exp_shift && acc < N) chk({tag, "_enc_q"}, 32'(enc_q_sig), 32'(bits[acc]));
         if (done_due) begin
            if (exp_done_cyc >= 0) chk({tag, "_done_cycle"}, cyc, exp_done_cyc);
            fin = 1;
         end
         if (exp_shift) begin
            if (acc < N) acc++; else tails++;
            issued++;
         end
         if (exp_valid && sym_ready_sig) begin
            sidx++;
            if (sidx == N + T) done_due = 1;
         end
         if (cyc == stop_at) begin
            @(negedge clk_sig);
            clk_run = 0;
            #2 rst_sig = 1'b1;
            #1 check_reset_outputs({tag, "_async_rst"});
            #5 rst_sig = 1'b0;
            clk_run = 1;
            return;
         end
         cyc++;
      end
      if (!fin) begin
         total++;
         $error("FAIL %s_timeout observed=%0d expected=done", tag, cyc);
      end
   endtask

   initial begin
      rst_sig = 1'b1; start_sig = 1'b0; abort_sig = 1'b0;
      bit_sig = 1'b0; bit_valid_sig = 1'b0; sym_ready_sig = 1'b1;
      #12;
      check_reset_outputs("reset");
      @(negedge clk_sig);
      rst_sig = 1'b0;

      run_frame("basic",    4'b1101, 0, 0, -1, -1, N + T + 3);
      run_frame("stall",    4'b1101, 1, 0, -1, -1, N + T + 6);
      run_frame("gaps",     4'b1101, 0, 1, -1, -1, -1);
      run_frame("ones",     4'b1111, 0, 0, -1, -1, N + T + 3);
      run_frame("zeros",    4'b0000, 0, 0, -1, -1, N + T + 3);
      run_frame("abort",    4'($urandom), 0, 0, 5, -1, -1);
      run_frame("post_abt", 4'b1011, 0, 0, -1, -1, N + T + 3);
      run_frame("rst_tail", 4'b1101, 0, 0, -1, 7, -1);
      run_frame("post_rst", 4'b0110, 0, 0, -1, -1, N + T + 3);
      for (int i = 0; i < 8; i++)
         run_frame("rand", 4'($urandom), 2, 2, -1, -1, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
